// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
package div_issue_ctrl_pkg;

    // Issue FSM: waiting for an operand, letting the divider settle, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient reported for any zero divisor, signed or unsigned.
    localparam logic [31:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;
    // Most negative 32-bit value; also the saturated result of INT_MIN / -1.
    localparam logic [31:0] INT_MIN          = 32'h8000_0000;

    // Two's-complement magnitude over 32 bits, applied only when take is set.
    // |INT_MIN| wraps back to INT_MIN, which the unsigned divider reads as 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic take);
        return (take && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_issue_ctrl_udiv.sv
// Combinational non-restoring unsigned 32/32 divider, quotient only.
module div_issue_ctrl_udiv (
    input  logic        en_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quot_o
);

    logic [33:0] rem;
    logic [31:0] q;

    // Unrolled non-restoring recurrence; a negative partial remainder is kept and repaired
    // by adding the divisor on the next step instead of restoring it immediately.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path can infer a latch.
        rem = '0;
        q   = '0;
        for (int i = 31; i >= 0; i--) begin
            // NOTE: blocking assignments here are intentional; each step consumes the previous step's remainder.
            if (!rem[33]) begin
                rem = {rem[32:0], dividend_i[i]} - {2'b00, divisor_i};
            end else begin
                rem = {rem[32:0], dividend_i[i]} + {2'b00, divisor_i};
            end
            q[i] = ~rem[33];
        end
        quot_o = en_i ? q : '0;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/retire controller around a multicycle combinational divider.
// The path from mag_a_q/mag_b_q through the divider into out_quot_q is a
// DIV_CYCLES multicycle path: the operands are frozen for the whole CALC phase
// and the quotient is only sampled on the edge that leaves CALC.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 4   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_signed,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_quot,
    output logic        out_dz,
    output logic        out_ovf
);

    localparam logic [3:0] CNT_INIT = 4'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [31:0] out_quot_q, out_quot_d;
    logic        out_dz_q, out_dz_d;
    logic        out_ovf_q, out_ovf_d;
    logic        live_q;

    logic        div_en;
    logic [31:0] udiv_quot;
    logic [31:0] final_quot;
    logic        accept;

    assign div_en    = (state_q == CALC);
    assign in_ready  = live_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_quot  = out_quot_q;
    assign out_dz    = out_dz_q;
    assign out_ovf   = out_ovf_q;
    assign accept    = in_valid && in_ready && !flush;

    div_issue_ctrl_udiv u_udiv (
        .en_i       (div_en),
        .dividend_i (mag_a_q),
        .divisor_i  (mag_b_q),
        .quot_o     (udiv_quot)
    );

    // Exceptional results override the signed fix-up of the unsigned quotient.
    always_comb begin
        if (dz_q) begin
            final_quot = DIV_BY_ZERO_QUOT;
        end else if (ovf_q) begin
            final_quot = INT_MIN;
        end else if (neg_q) begin
            final_quot = ~udiv_quot + 32'd1;
        end else begin
            final_quot = udiv_quot;
        end
    end

    // Next-state and datapath-capture logic; flush overrides everything else.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        neg_d      = neg_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        out_quot_d = out_quot_q;
        out_dz_d   = out_dz_q;
        out_ovf_d  = out_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mag_a_d = mag32(in_a, in_signed);
                    mag_b_d = mag32(in_b, in_signed);
                    neg_d   = in_signed && (in_a[31] ^ in_b[31]);
                    dz_d    = (in_b == 32'd0);
                    ovf_d   = in_signed && (in_a == INT_MIN) && (in_b == 32'hFFFF_FFFF);
                    cnt_d   = CNT_INIT;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == 4'd0) begin
                    out_quot_d = final_quot;
                    out_dz_d   = dz_q;
                    out_ovf_d  = ovf_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand registers are reset too, so nothing stale can reach the divider after reset.
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            neg_q      <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            out_quot_q <= '0;
            out_dz_q   <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            neg_q      <= neg_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            out_quot_q <= out_quot_d;
            out_dz_q   <= out_dz_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    // Holds in_ready low while in reset and releases it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench: directed cases plus randomized operations on DIV_CYCLES=4 and =1.
module tb_div_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [2];
    logic        in_ready_s  [2];
    logic [31:0] in_a_s      [2];
    logic [31:0] in_b_s      [2];
    logic        in_signed_s [2];
    logic        flush_s     [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];
    logic [31:0] out_quot_s  [2];
    logic        out_dz_s    [2];
    logic        out_ovf_s   [2];

    int n_checks = 0;
    int n_pass   = 0;

    div_issue_ctrl #(.DIV_CYCLES(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready_s[0]),
        .in_a      (in_a_s[0]),
        .in_b      (in_b_s[0]),
        .in_signed (in_signed_s[0]),
        .flush     (flush_s[0]),
        .out_valid (out_valid_s[0]),
        .out_ready (out_ready_s[0]),
        .out_quot  (out_quot_s[0]),
        .out_dz    (out_dz_s[0]),
        .out_ovf   (out_ovf_s[0])
    );

    div_issue_ctrl #(.DIV_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready_s[1]),
        .in_a      (in_a_s[1]),
        .in_b      (in_b_s[1]),
        .in_signed (in_signed_s[1]),
        .flush     (flush_s[1]),
        .out_valid (out_valid_s[1]),
        .out_ready (out_ready_s[1]),
        .out_quot  (out_quot_s[1]),
        .out_dz    (out_dz_s[1]),
        .out_ovf   (out_ovf_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: language-level division with the exceptional cases applied first.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic dz, output logic ovf);
        dz  = 1'b0;
        ovf = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q   = 32'h8000_0000;
            ovf = 1'b1;
        end else if (s) begin
            q = $signed(a) / $signed(b);
        end else begin
            q = a / b;
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            6:       return 32'd0 - 32'($urandom_range(1, 255));
            default: return $urandom();
        endcase
    endfunction

    task automatic wait_ready(input int sel);
        int guard = 0;
        while (!in_ready_s[sel] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 32'(in_ready_s[sel]), 32'd1);
    endtask

    // One full transaction: issue, measure latency, check result, hold, consume.
    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int hold, output logic [31:0] q_seen);
        logic [31:0] eq;
        logic        edz, eovf;
        int          lat;
        int          dc;
        dc = (sel == 0) ? 4 : 1;
        model(a, b, s, eq, edz, eovf);
        wait_ready(sel);
        in_valid_s[sel]  = 1'b1;
        in_a_s[sel]      = a;
        in_b_s[sel]      = b;
        in_signed_s[sel] = s;
        @(negedge clk);
        in_valid_s[sel]  = 1'b0;
        in_a_s[sel]      = $urandom();
        in_b_s[sel]      = $urandom();
        in_signed_s[sel] = 1'($urandom());
        check("busy_after_accept", 32'(in_ready_s[sel]), 32'd0);
        lat = 0;
        while (!out_valid_s[sel] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(dc));
        check("quot", out_quot_s[sel], eq);
        check("dz", 32'(out_dz_s[sel]), 32'(edz));
        check("ovf", 32'(out_ovf_s[sel]), 32'(eovf));
        q_seen = out_quot_s[sel];
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_quot", out_quot_s[sel], eq);
            check("hold_valid", 32'(out_valid_s[sel]), 32'd1);
            check("hold_not_ready", 32'(in_ready_s[sel]), 32'd0);
        end
        out_ready_s[sel] = 1'b1;
        @(negedge clk);
        out_ready_s[sel] = 1'b0;
        check("consumed_valid", 32'(out_valid_s[sel]), 32'd0);
        check("consumed_ready", 32'(in_ready_s[sel]), 32'd1);
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] ra, rb;
        int          lat;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_s[i]  = 1'b0;
            in_a_s[i]      = '0;
            in_b_s[i]      = '0;
            in_signed_s[i] = 1'b0;
            flush_s[i]     = 1'b0;
            out_ready_s[i] = 1'b0;
        end
        #1;
        check("rst_in_ready", 32'(in_ready_s[0]), 32'd0);
        check("rst_out_valid", 32'(out_valid_s[0]), 32'd0);
        check("rst_out_quot", out_quot_s[0], 32'd0);
        check("rst_out_dz", 32'(out_dz_s[0]), 32'd0);
        check("rst_out_ovf", 32'(out_ovf_s[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_in_ready", 32'(in_ready_s[1]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready4", 32'(in_ready_s[0]), 32'd1);
        check("post_rst_ready1", 32'(in_ready_s[1]), 32'd1);

        // Directed results on DIV_CYCLES=4.
        do_op(0, 32'd100, 32'd7, 1'b0, 0, q);
        check("u_100_7", q, 32'd14);
        do_op(0, 32'hFFFF_FF9C, 32'd7, 1'b1, 0, q);
        check("s_m100_7", q, 32'hFFFF_FFF2);
        do_op(0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 0, q);
        check("s_m100_m7", q, 32'd14);
        do_op(0, 32'd5, 32'd0, 1'b1, 0, q);
        check("dz_5_0", q, 32'hFFFF_FFFF);
        do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, q);
        check("ovf_min_m1", q, 32'h8000_0000);
        do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, q);
        check("u_min_m1", q, 32'd0);
        do_op(0, 32'h8000_0000, 32'd1, 1'b1, 0, q);
        check("s_min_1", q, 32'h8000_0000);

        // Backpressure for 10 cycles.
        do_op(0, 32'd1000, 32'd33, 1'b0, 10, q);
        check("bp_quot", q, 32'd30);

        // Flush during the second CALC cycle.
        wait_ready(0);
        in_valid_s[0] = 1'b1;
        in_a_s[0]     = 32'd77;
        in_b_s[0]     = 32'd7;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        flush_s[0] = 1'b1;
        @(negedge clk);
        flush_s[0] = 1'b0;
        check("flush_valid", 32'(out_valid_s[0]), 32'd0);
        check("flush_ready", 32'(in_ready_s[0]), 32'd1);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid_s[0]) lat++;
        end
        check("flush_no_result", 32'(lat), 32'd0);

        // Reset pulse while a result is presented.
        wait_ready(0);
        in_valid_s[0]  = 1'b1;
        in_a_s[0]      = 32'd5;
        in_b_s[0]      = 32'd0;
        in_signed_s[0] = 1'b1;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        lat = 0;
        while (!out_valid_s[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("pre_rst_dz", 32'(out_dz_s[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_done_valid", 32'(out_valid_s[0]), 32'd0);
        check("rst_done_quot", out_quot_s[0], 32'd0);
        check("rst_done_dz", 32'(out_dz_s[0]), 32'd0);
        check("rst_done_ovf", 32'(out_ovf_s[0]), 32'd0);
        check("rst_done_ready", 32'(in_ready_s[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(in_ready_s[0]), 32'd1);
        check("rst_release_valid", 32'(out_valid_s[0]), 32'd0);

        // Directed result on DIV_CYCLES=1.
        do_op(1, 32'd100, 32'd7, 1'b0, 0, q);
        check("dc1_u_100_7", q, 32'd14);

        // Randomized operations on both configurations.
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 5000; i++) begin
                ra = rand_word();
                rb = rand_word();
                do_op(sel, ra, rb, 1'($urandom()), int'($urandom_range(0, 2)), q);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 The block SHALL have the parameter DIV_CYCLES, default 4, giving the number of settle cycles allowed for the combinational divider; the legal range is 1 to 15.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning an operation is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept an operation.
REQ-006 The block SHALL have port in_a, input, 32 bits, the dividend.
REQ-007 The block SHALL have port in_b, input, 32 bits, the divisor.
REQ-008 The block SHALL have port in_signed, input, 1 bit: 1 selects two's-complement division, 0 selects unsigned division.
REQ-009 The block SHALL have port flush, input, 1 bit, a synchronous abort.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-012 The block SHALL have port out_quot, output, 32 bits, the quotient.
REQ-013 The block SHALL have port out_dz, output, 1 bit, the divide-by-zero flag.
REQ-014 The block SHALL have port out_ovf, output, 1 bit, the signed-overflow flag.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 Accept: on an edge in IDLE with in_valid=1 and flush=0, the block SHALL register the following and go to CALC with cnt=DIV_CYCLES-1:
- |in_a| and |in_b|, taking magnitudes only when in_signed=1;
- neg = in_signed & (in_a[31] ^ in_b[31]);
- dz = (in_b==0);
- ovf = in_signed & (in_a==32'h80000000) & (in_b==32'hFFFFFFFF).
REQ-017 Magnitude SHALL be computed as two's-complement negation over 32 bits, so |0x80000000| = 0x80000000.
REQ-018 The divider enable SHALL be 1 only in CALC; the registered magnitudes SHALL be held stable throughout CALC.
REQ-019 In CALC, each edge SHALL decrement cnt; on the edge where cnt==0, the block SHALL capture the final quotient into out_quot, capture dz/ovf into out_dz/out_ovf, and go to DONE.
REQ-020 Final quotient selection:
- dz=1 -> 32'hFFFFFFFF, independent of sign;
- ovf=1 -> 32'h80000000;
- otherwise -> the negation of the unsigned quotient if neg=1, else the unsigned quotient.
REQ-021 Latency: out_valid SHALL rise on the DIV_CYCLES-th rising edge after the accepting edge.
REQ-022 DONE SHALL hold out_quot, out_dz and out_ovf constant until out_valid&out_ready, then return to IDLE on that edge.
REQ-023 A new operation SHALL NOT be accepted in the same cycle as output consumption; minimum issue interval is DIV_CYCLES+2 cycles.
REQ-024 flush=1 on any edge SHALL force IDLE and clear out_valid; any in-flight or unconsumed result SHALL be discarded.
REQ-025 flush has priority over accept and over output handshake.
REQ-026 Inputs in_a, in_b and in_signed SHALL be ignored outside the accepting edge.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, cnt=0, out_valid=0, out_quot=0, out_dz=0, out_ovf=0, and all operand registers to 0.
REQ-028 During reset in_ready SHALL read 0; it SHALL be 1 from the first edge after rst_n deasserts.
REQ-029 Reset asserted mid-CALC or mid-DONE SHALL discard the operation with no result emitted.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE/CALC/DONE), DIV_BY_ZERO_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000.
REQ-031 The design SHALL contain exactly one sub-module, the existing non-restoring unsigned divider, fed the registered magnitudes and enable.
REQ-032 The divider path SHALL be constrained as a DIV_CYCLES multicycle path.

Verification
REQ-033 Unsigned: a=100, b=7, signed=0 -> out_quot=14, dz=0, ovf=0, with out_valid rising exactly 4 edges after accept (DIV_CYCLES=4).
REQ-034 Signed: a=-100 (0xFFFFFF9C), b=7 -> out_quot=0xFFFFFFF2 (-14); a=-100, b=-7 -> out_quot=14.
REQ-035 Zero divisor: a=5, b=0, signed=1 -> out_quot=0xFFFFFFFF, out_dz=1; a=0x80000000, b=0xFFFFFFFF, signed=1 -> out_quot=0x80000000, out_ovf=1.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles -> out_quot stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-037 Flush and reset: flush in the 2nd CALC cycle -> no out_valid, in_ready=1 the next cycle; rst_n pulse in DONE -> all outputs 0 immediately.
REQ-038 Random: 10k random signed/unsigned operations with random out_ready checked against a reference model, including DIV_CYCLES=1.
